// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES cores.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req/wr/lock   per-core request, write flag and keep-grant flag
//   addr/wdata    flattened per-core address / write data, core k at [k*W +: W]
//   gnt           one-hot combinational grant
//   rvalid/rdata  one-hot registered read-return strobe, shared read data
//   mem_*         single-port memory interface (sync read, 1-cycle latency)
//   conflict_cnt  saturating count of cycles with two or more requesters
module dm_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_LOCK  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          wr,
    input  logic [NUM_CORES-1:0]          lock,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    input  logic [NUM_CORES*DATA_W-1:0]   wdata,
    output logic [NUM_CORES-1:0]          gnt,
    output logic [NUM_CORES-1:0]          rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_wr,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [15:0]                   conflict_cnt
);

    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

    lock_state_e             state_q, state_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic [CntW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [NUM_CORES-1:0]    rvalid_q, rvalid_d;
    logic [15:0]             conflict_q, conflict_d;

    logic                    hold;
    logic                    forced;
    logic [NUM_CORES-1:0]    owner_oh;
    logic [NUM_CORES-1:0]    cand;
    logic                    win_found;
    logic [IdxW-1:0]         win_idx;
    logic [IdxW-1:0]         idx;
    logic                    multi_req;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StUnlocked;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            ptr_q      <= IdxW'(NUM_CORES - 1);
            rvalid_q   <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            ptr_q      <= ptr_d;
            rvalid_q   <= rvalid_d;
            conflict_q <= conflict_d;
        end
    end

    // Arbitration and memory-port outputs
    always_comb begin
        // The owner keeps the port only while it requests and has budget left.
        hold   = (state_q == StLocked) && req[owner_q] && (lock_cnt_q != CntW'(MAX_LOCK));
        forced = (state_q == StLocked) && (lock_cnt_q == CntW'(MAX_LOCK));

        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;

        // On a forced release the owner steps aside, unless nobody else is waiting.
        cand = req;
        if (forced && |(req & ~owner_oh)) begin
            cand = req & ~owner_oh;
        end

        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int unsigned i = 1; i <= NUM_CORES; i++) begin
            idx = IdxW'((32'(ptr_q) + i) % NUM_CORES);
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end

        if (hold) begin
            win_found = 1'b1;
            win_idx   = owner_q;
        end

        if (rst) begin
            win_found = 1'b0;
        end

        gnt          = '0;
        gnt[win_idx] = win_found;

        // With no grant win_idx is 0, so the port shows core 0's fields.
        mem_addr  = addr[32'(win_idx) * ADDR_W +: ADDR_W];
        mem_wdata = wdata[32'(win_idx) * DATA_W +: DATA_W];
        mem_wr    = win_found & wr[win_idx];

        rvalid       = rvalid_q & {NUM_CORES{~rst}};
        rdata        = mem_rdata;
        conflict_cnt = conflict_q;
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        ptr_d      = ptr_q;

        if (win_found) begin
            ptr_d = win_idx;
        end

        if (hold && lock[owner_q]) begin
            state_d    = StLocked;
            lock_cnt_d = lock_cnt_q + CntW'(1);
        end else if (win_found && !hold && lock[win_idx]) begin
            state_d    = StLocked;
            owner_d    = win_idx;
            lock_cnt_d = CntW'(1);
        end else begin
            state_d    = StUnlocked;
            lock_cnt_d = '0;
        end

        rvalid_d = gnt & ~wr;

        multi_req  = |(req & (req - {{(NUM_CORES - 1){1'b0}}, 1'b1}));
        conflict_d = conflict_q;
        if (multi_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     req;
    logic [NC-1:0]     wr;
    logic [NC-1:0]     lock;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  wdata;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wr;
    logic [DW-1:0]     mem_rdata;
    logic [15:0]       conflict_cnt;

    logic [DW-1:0]     mem [0:65535];

    typedef struct packed {
        logic [1:0] core;
        logic [7:0] data;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    int    vectors;
    int    miscompares;
    logic [NC-1:0] exp_rv;
    logic [NC-1:0] exp_g;

    dm_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_LOCK  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .wr           (wr),
        .lock         (lock),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr       (mem_wr),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read single-port memory, read-before-write
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Inputs change 1 time unit after the edge; checks happen 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        rst  = 1'b1;
        req  = '0;
        wr   = '0;
        lock = '0;
        step();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        wr   = 4'b1111;
        lock = 4'b1111;
        step();
        #2;
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000);
        end
        vectors++;
        if (mem_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_wr: got %b want 0", mem_wr);
        end
        vectors++;
        if (rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_rvalid: got %b want 0000", rvalid);
        end
        vectors++;
        if (conflict_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_conflict: got %h want 0000", conflict_cnt);
        end
    endtask

    task automatic test_single_read();
        step();
        rst  = 1'b0;
        req  = 4'b0001;
        wr   = 4'b0000;
        lock = 4'b0000;
        addr[0 +: AW] = 16'h0010;
        #2;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_gnt: got %b want 0001", gnt);
        end
        vectors++;
        if (mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL single_port: got addr=%h wr=%b want addr=0010 wr=0", mem_addr, mem_wr);
        end
        sb.push_back('{core: 2'd0, data: 8'hA5});
        step();
        req = 4'b0000;
        #2;
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_idle_gnt: got %b want 0000", gnt);
        end
        exp_rv = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv = 4'b0001 << e.core;
        end
        vectors++;
        if (rvalid !== exp_rv) begin
            miscompares++;
            $display("FAIL single_rvalid: got %b want %b", rvalid, exp_rv);
        end
        if (exp_rv != 0) begin
            vectors++;
            if (rdata !== e.data) begin
                miscompares++;
                $display("FAIL single_rdata: got %h want %h", rdata, e.data);
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < NC; k++) addr[k*AW +: AW] = 16'(16'h0020 + k);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            req = 4'b1111;
            wr  = 4'b0000;
            #2;
            exp_g = 4'b0001 << (i % 4);
            vectors++;
            if (gnt !== exp_g) begin
                miscompares++;
                $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_g);
            end
            vectors++;
            if (conflict_cnt !== 16'(i)) begin
                miscompares++;
                $display("FAIL rr_conflict[%0d]: got %0d want %0d", i, conflict_cnt, i);
            end
            exp_rv = '0;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_rv = 4'b0001 << e.core;
            end
            vectors++;
            if (rvalid !== exp_rv) begin
                miscompares++;
                $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rvalid, exp_rv);
            end
            if (exp_rv != 0) begin
                vectors++;
                if (rdata !== e.data) begin
                    miscompares++;
                    $display("FAIL rr_rdata[%0d]: got %h want %h", i, rdata, e.data);
                end
            end
            sb.push_back('{core: 2'(i % 4), data: 8'(8'h50 + (i % 4))});
        end
        step();
        req = 4'b0000;
        #2;
        exp_rv = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv = 4'b0001 << e.core;
        end
        vectors++;
        if (rvalid !== exp_rv || (exp_rv != 0 && rdata !== e.data)) begin
            miscompares++;
            $display("FAIL rr_last_return: got %b/%h want %b/%h", rvalid, rdata, exp_rv, e.data);
        end
    endtask

    task automatic test_write_then_read();
        step();
        req   = 4'b0100;
        wr    = 4'b0100;
        addr[2*AW +: AW]  = 16'h0100;
        wdata[2*DW +: DW] = 8'h3C;
        #2;
        vectors++;
        if (gnt !== 4'b0100 || mem_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_grant: got gnt=%b wr=%b want 0100/1", gnt, mem_wr);
        end
        vectors++;
        if (mem_addr !== 16'h0100 || mem_wdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL wr_port: got %h/%h want 0100/3c", mem_addr, mem_wdata);
        end
        step();
        req = 4'b0010;
        wr  = 4'b0000;
        addr[1*AW +: AW] = 16'h0100;
        #2;
        vectors++;
        if (gnt !== 4'b0010 || mem_wr !== 1'b0 || rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_grant: got gnt=%b wr=%b rv=%b want 0010/0/0000", gnt, mem_wr, rvalid);
        end
        sb.push_back('{core: 2'd1, data: 8'h3C});
        step();
        req = 4'b0000;
        #2;
        exp_rv = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv = 4'b0001 << e.core;
        end
        vectors++;
        if (rvalid !== exp_rv || mem_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_rvalid: got %b wr=%b want %b wr=0", rvalid, mem_wr, exp_rv);
        end
        if (exp_rv != 0) begin
            vectors++;
            if (rdata !== e.data) begin
                miscompares++;
                $display("FAIL rd_rdata: got %h want %h", rdata, e.data);
            end
        end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int i = 1; i <= 17; i++) begin
            if (i > 1) step();
            req  = 4'b1010;
            wr   = 4'b1010;
            lock = 4'b0010;
            #2;
            exp_g = (i <= 16) ? 4'b0010 : 4'b1000;
            vectors++;
            if (gnt !== exp_g || mem_wr !== 1'b1 || rvalid !== 4'b0000) begin
                miscompares++;
                $display("FAIL lock_gnt[%0d]: got %b wr=%b rv=%b want %b/1/0000",
                         i, gnt, mem_wr, rvalid, exp_g);
            end
        end
        step();
        req  = 4'b0000;
        wr   = 4'b0000;
        lock = 4'b0000;
    endtask

    task automatic test_reset_suppress();
        step();
        req = 4'b0001;
        wr  = 4'b0000;
        addr[0 +: AW] = 16'h0010;
        #2;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL rs_gnt: got %b want 0001", gnt);
        end
        step();
        rst = 1'b1;
        req = 4'b0000;
        #2;
        vectors++;
        if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL rs_rvalid: got rv=%b gnt=%b want 0000/0000", rvalid, gnt);
        end
        step();
        rst = 1'b0;
        req = 4'b1001;
        #2;
        vectors++;
        if (gnt !== 4'b0001 || rvalid !== 4'b0000) begin
            miscompares++;
            $display("FAIL rs_ptr: got gnt=%b rv=%b want 0001/0000", gnt, rvalid);
        end
        sb.push_back('{core: 2'd0, data: 8'hA5});
        step();
        req = 4'b1000;
        #2;
        vectors++;
        if (gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL rs_next_gnt: got %b want 1000", gnt);
        end
        exp_rv = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rv = 4'b0001 << e.core;
        end
        vectors++;
        if (rvalid !== exp_rv || (exp_rv != 0 && rdata !== e.data)) begin
            miscompares++;
            $display("FAIL rs_return: got %b/%h want %b/%h", rvalid, rdata, exp_rv, e.data);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        req = 4'b0011;
        wr  = 4'b0000;
        repeat (65534) step();
        #2;
        vectors++;
        if (conflict_cnt !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL sat_pre: got %h want fffe", conflict_cnt);
        end
        step();
        #2;
        vectors++;
        if (conflict_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hit: got %h want ffff", conflict_cnt);
        end
        repeat (4500) step();
        #2;
        vectors++;
        if (conflict_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_hold: got %h want ffff", conflict_cnt);
        end
        req = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        req   = '0;
        wr    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0010] = 8'hA5;
        for (int k = 0; k < NC; k++) mem[16'h0020 + k] = 8'(8'h50 + k);

        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read();
        test_lock();
        test_reset_suppress();
        test_saturate();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
